uart_tx_cfg: RTL

- Parametrised successor to the current UART transmitter, in the same serial subsystem.
- Runtime-selectable frame format:
  - data length 5..DBITS
  - parity none/even/odd
  - 1 or 2 stop bits
- Adds explicit ready/busy handshake, registered glitch-free tx output and configuration latching per frame.
- Driven by the shared baud-rate tick generator (s_tick); feeds the UART pin or a TX FIFO drain path.

---
 rtl/uart_tx_cfg.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_cfg.sv
// UART transmitter with a per-frame latched format: 5..DBITS data bits,
// none/even/odd parity and 1 or 2 stop bits, paced by an oversampling tick.
module uart_tx_cfg #(
   parameter int unsigned DBITS      = 8,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         s_tick,
   input  logic [DBITS-1:0]             tx_din,
   input  logic                         tx_start,
   input  logic [$clog2(DBITS+1)-1:0]   cfg_nbits,
   input  logic [1:0]                   cfg_parity,
   input  logic                         cfg_stop2,
   output logic                         tx_ready,
   output logic                         tx_done_tick,
   output logic                         tx
);

   localparam int unsigned NW = $clog2(DBITS + 1);
   localparam int unsigned SW = $clog2(OVERSAMPLE);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t           state_q, state_d;
   logic [SW-1:0]    s_q, s_d;
   logic [NW-1:0]    n_q, n_d;
   logic [NW-1:0]    nbits_q, nbits_d;
   logic [DBITS-1:0] shift_q, shift_d;
   logic             par_q, par_d;
   logic             par_en_q, par_en_d;
   logic             par_odd_q, par_odd_d;
   logic             stop2_q, stop2_d;
   logic             stopc_q, stopc_d;
   logic             tx_q, tx_d;
   logic             done;
   logic             bound;
   logic [NW-1:0]    nbits_clamped;

   always_comb begin
      nbits_clamped = cfg_nbits;
      if (cfg_nbits < NW'(5))
         nbits_clamped = NW'(5);
      else if (cfg_nbits > NW'(DBITS))
         nbits_clamped = NW'(DBITS);
   end

   assign bound = s_tick && (s_q == SW'(OVERSAMPLE - 1));

   always_comb begin
      state_d   = state_q;
      s_d       = s_q;
      n_d       = n_q;
      nbits_d   = nbits_q;
      shift_d   = shift_q;
      par_d     = par_q;
      par_en_d  = par_en_q;
      par_odd_d = par_odd_q;
      stop2_d   = stop2_q;
      stopc_d   = stopc_q;
      done      = 1'b0;

      if (state_q != IDLE && s_tick)
         s_d = bound ? '0 : s_q + SW'(1);

      case (state_q)
         IDLE: begin
            if (tx_start) begin
               shift_d   = tx_din;
               nbits_d   = nbits_clamped;
               par_en_d  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
               par_odd_d = (cfg_parity == 2'b10);
               stop2_d   = cfg_stop2;
               s_d       = '0;
               n_d       = '0;
               par_d     = 1'b0;
               stopc_d   = 1'b0;
               state_d   = START;
            end
         end
         START: begin
            if (bound)
               state_d = DATA;
         end
         DATA: begin
            if (bound) begin
               shift_d = shift_q >> 1;
               par_d   = par_q ^ shift_q[0];
               n_d     = n_q + NW'(1);
               if (n_q == nbits_q - NW'(1))
                  state_d = par_en_q ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bound)
               state_d = STOP;
         end
         STOP: begin
            if (bound) begin
               if (stop2_q && !stopc_q) begin
                  stopc_d = 1'b1;
               end else begin
                  stopc_d = 1'b0;
                  done    = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // tx is decoded from the next state so the pin changes on the same edge as the FSM
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = par_d ^ par_odd_q;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         s_q       <= '0;
         n_q       <= '0;
         nbits_q   <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         stop2_q   <= 1'b0;
         stopc_q   <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         s_q       <= s_d;
         n_q       <= n_d;
         nbits_q   <= nbits_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         par_en_q  <= par_en_d;
         par_odd_q <= par_odd_d;
         stop2_q   <= stop2_d;
         stopc_q   <= stopc_d;
         tx_q      <= tx_d;
      end
   end

   assign tx           = tx_q;
   assign tx_ready     = (state_q == IDLE);
   assign tx_done_tick = done;

endmodule
